prog_loader: RTL

- Byte-stream program loader. It is the producer side of the CPU's testbench load port.
- Accepts a framed byte stream over a valid/ready input and drives ins_write / instruction_write_data into instruction memory, and mem_write_data_tb / access_addr_tb into data memory.
- Holds the CPU in reset for the whole load. Releases it only after a good checksum.
- Sits between the host link (UART receiver or bench) and CPU top level.

---
 rtl/loader_pkg.sv | 19 +
 rtl/loader_csum.sv | 26 ++
 rtl/prog_loader.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the byte-stream program loader: state encoding,
// default frame marker and checksum width.
package loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ICNT  = 3'd1,
    S_INSTR = 3'd2,
    S_DCNT  = 3'd3,
    S_DATA  = 3'd4,
    S_CSUM  = 3'd5,
    S_DONE  = 3'd6,
    S_ERR   = 3'd7
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         CSUM_W        = 8;

endpackage

// File: rtl/loader_csum.sv
// Modulo-2^CSUM_W running sum with synchronous clear; zero_next reports
// whether adding the current input byte would bring the sum to zero.
module loader_csum
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              add_en,
  input  logic [CSUM_W-1:0] data,
  output logic [CSUM_W-1:0] sum,
  output logic              zero_next
);

  logic [CSUM_W-1:0] sum_nxt;

  assign sum_nxt   = sum + data;
  assign zero_next = (sum_nxt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       sum <= '0;
    else if (clr)    sum <= '0;
    else if (add_en) sum <= sum_nxt;
  end

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader: writes instruction and data memories through the
// CPU test port and holds the CPU in reset until a frame checks out.
module prog_loader
  import loader_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF,
  parameter int         IMEM_DEPTH = 256,
  parameter int         DMEM_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       ins_write,
  output logic       ins_strobe,
  output logic [7:0] instruction_write_data,
  output logic       dmem_strobe,
  output logic [3:0] access_addr_tb,
  output logic [7:0] mem_write_data_tb,
  output logic       cpu_reset,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] load_count
);

  localparam logic [7:0] DMAX   = 8'(DMEM_DEPTH);
  localparam logic [7:0] LC_MAX = 8'(IMEM_DEPTH - 1);

  state_t     state;
  logic [7:0] rem;
  logic [3:0] idx;
  logic       accept;
  logic       is_sync;
  logic       csum_clr;
  logic       csum_add;
  logic       csum_ok;
  logic [7:0] sum;

  assign accept   = in_valid && in_ready;
  assign is_sync  = (in_data == SYNC_BYTE);
  assign csum_clr = accept && is_sync && (state inside {S_IDLE, S_DONE, S_ERR});
  assign csum_add = accept && (state inside {S_ICNT, S_INSTR, S_DCNT, S_DATA});

  loader_csum u_csum (
    .clk       (clk),
    .reset     (reset),
    .clr       (csum_clr),
    .add_en    (csum_add),
    .data      (in_data),
    .sum       (sum),
    .zero_next (csum_ok)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                  <= S_IDLE;
      in_ready               <= 1'b1;
      ins_write              <= 1'b0;
      ins_strobe             <= 1'b0;
      instruction_write_data <= '0;
      dmem_strobe            <= 1'b0;
      access_addr_tb         <= '0;
      mem_write_data_tb      <= '0;
      cpu_reset              <= 1'b1;
      busy                   <= 1'b0;
      done                   <= 1'b0;
      error                  <= 1'b0;
      load_count             <= '0;
      rem                    <= '0;
      idx                    <= '0;
    end else begin
      ins_strobe  <= 1'b0;
      dmem_strobe <= 1'b0;
      in_ready    <= 1'b1;
      // CPU leaves reset one cycle after done, once load mode is already off
      if (state == S_DONE) cpu_reset <= 1'b0;
      if (accept) begin
        case (state)
          S_IDLE, S_DONE, S_ERR: begin
            if (is_sync) begin
              state      <= S_ICNT;
              busy       <= 1'b1;
              ins_write  <= 1'b1;
              cpu_reset  <= 1'b1;
              done       <= 1'b0;
              error      <= 1'b0;
              load_count <= '0;
            end
          end
          S_ICNT: begin
            rem   <= in_data;
            state <= (in_data == 8'd0) ? S_DCNT : S_INSTR;
          end
          S_INSTR: begin
            instruction_write_data <= in_data;
            ins_strobe             <= 1'b1;
            if (load_count != LC_MAX) load_count <= load_count + 8'd1;
            rem <= rem - 8'd1;
            if (rem == 8'd1) state <= S_DCNT;
          end
          S_DCNT: begin
            if (in_data > DMAX) begin
              // Oversized data count: abort and stall input for one cycle
              state     <= S_ERR;
              error     <= 1'b1;
              busy      <= 1'b0;
              ins_write <= 1'b0;
              in_ready  <= 1'b0;
            end else if (in_data == 8'd0) begin
              state <= S_CSUM;
            end else begin
              rem   <= in_data;
              idx   <= '0;
              state <= S_DATA;
            end
          end
          S_DATA: begin
            access_addr_tb    <= idx;
            mem_write_data_tb <= in_data;
            dmem_strobe       <= 1'b1;
            idx               <= idx + 4'd1;
            rem               <= rem - 8'd1;
            if (rem == 8'd1) state <= S_CSUM;
          end
          S_CSUM: begin
            busy      <= 1'b0;
            ins_write <= 1'b0;
            if (csum_ok) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_ERR;
              error <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
